// File: rtl/memory_bus_initiator_pkg.sv
// Memory bus packet types plus the initiator's FSM state encoding.
package memory_bus_initiator_pkg;

   localparam int BUS_DATA_W = 64;
   localparam int BUS_SRC_W  = 4;

   typedef enum logic {
      bus_read_data  = 1'b0,
      bus_write_data = 1'b1
   } bus_packet_type_t;

   typedef logic [BUS_DATA_W-1:0] bus_packet_payload_t;
   typedef logic [BUS_SRC_W-1:0]  memory_bus_source_t;

   typedef struct packed {
      bus_packet_type_t    ptype;
      logic [63:0]         address;
      bus_packet_payload_t payload;
   } BusPacket;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RESP,
      RESPOND
   } memory_bus_initiator_state_t;

endpackage

// File: rtl/bus_response_watchdog.sv
// Read-response watchdog: counts cycles while run is high, restarts from zero
// whenever run drops, and flags expiry on the LIMIT-th running cycle.
module bus_response_watchdog #(
   parameter int LIMIT = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic expired
);
   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         count <= '0;
      else if (!run)     count <= '0;
      else if (!expired) count <= count + CW'(1);
   end

   assign expired = run && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/memory_bus_initiator.sv
// Single-outstanding memory bus requester: client request -> bus packet ->
// (reads) matching response -> one-cycle completion. Optional read timeout
// is enabled by defining MEMORY_BUS_INITIATOR_TIMEOUT_EN.
module memory_bus_initiator
   import memory_bus_initiator_pkg::*;
#(
   parameter int SOURCE_ID      = 0,
   parameter int SRC_W          = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [63:0]      req_addr,
   input  logic [63:0]      req_wdata,
   output logic             resp_valid,
   output logic [63:0]      resp_rdata,
   output logic             resp_error,
   output logic             bus_req_valid,
   input  logic             bus_req_ready,
   output bus_packet_type_t bus_req_type,
   output logic [63:0]      bus_req_address,
   output logic [63:0]      bus_req_payload,
   output logic [SRC_W-1:0] bus_req_source,
   input  logic             bus_resp_valid,
   input  logic [63:0]      bus_resp_payload,
   input  logic [SRC_W-1:0] bus_resp_dest
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   memory_bus_initiator_state_t state, state_n;
   BusPacket    pkt;
   logic [63:0] rdata;
   logic        resp_hit;
   logic        timed_out;

   assign resp_hit = bus_resp_valid && (bus_resp_dest == SRC_W'(SOURCE_ID));

`ifdef MEMORY_BUS_INITIATOR_TIMEOUT_EN
   logic error;

   bus_response_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .run     (state == WAIT_RESP),
      .expired (timed_out)
   );

   // A matching response in the expiry cycle still wins over the timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                             error <= 1'b0;
      else if (state == IDLE && req_valid)                   error <= 1'b0;
      else if (state == WAIT_RESP && !resp_hit && timed_out) error <= 1'b1;
   end

   assign resp_error = (state == RESPOND) && error;
`else
   assign timed_out  = 1'b0;
   assign resp_error = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:      if (req_valid) state_n = ISSUE;
         ISSUE:     if (bus_req_ready)
                       state_n = (pkt.ptype == bus_write_data) ? RESPOND : WAIT_RESP;
         WAIT_RESP: if (resp_hit || timed_out) state_n = RESPOND;
         RESPOND:   state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   // Request latch; rdata stays 0 for writes and timed-out reads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt   <= '0;
         rdata <= '0;
      end else if (state == IDLE && req_valid) begin
         pkt.ptype   <= req_write ? bus_write_data : bus_read_data;
         pkt.address <= req_addr;
         pkt.payload <= req_write ? req_wdata : '0;
         rdata       <= '0;
      end else if (state == WAIT_RESP && resp_hit) begin
         rdata <= bus_resp_payload;
      end
   end

   // All outputs decode registered state only; bus fields read 0 when idle.
   assign req_ready       = (state == IDLE) && !reset;
   assign bus_req_valid   = (state == ISSUE);
   assign bus_req_type    = bus_req_valid ? pkt.ptype : bus_read_data;
   assign bus_req_address = bus_req_valid ? pkt.address : '0;
   assign bus_req_payload = bus_req_valid ? pkt.payload : '0;
   assign bus_req_source  = bus_req_valid ? SRC_W'(SOURCE_ID) : '0;
   assign resp_valid      = (state == RESPOND);
   assign resp_rdata      = resp_valid ? rdata : '0;

endmodule

// File: tb/tb_memory_bus_initiator.sv
// Directed + randomized bench for memory_bus_initiator; the bench acts as the
// bus responder backed by a byte-address memory map and predicts latency.
module tb_memory_bus_initiator;
   import memory_bus_initiator_pkg::*;

   localparam int SID = 3;
   localparam int TO  = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             req_valid, req_ready, req_write;
   logic [63:0]      req_addr, req_wdata;
   logic             resp_valid, resp_error;
   logic [63:0]      resp_rdata;
   logic             bus_req_valid, bus_req_ready;
   bus_packet_type_t bus_req_type;
   logic [63:0]      bus_req_address, bus_req_payload;
   logic [3:0]       bus_req_source;
   logic             bus_resp_valid;
   logic [63:0]      bus_resp_payload;
   logic [3:0]       bus_resp_dest;

   memory_bus_initiator #(.SOURCE_ID(SID), .SRC_W(4), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
      .bus_req_type(bus_req_type), .bus_req_address(bus_req_address),
      .bus_req_payload(bus_req_payload), .bus_req_source(bus_req_source),
      .bus_resp_valid(bus_resp_valid), .bus_resp_payload(bus_resp_payload),
      .bus_resp_dest(bus_resp_dest)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int n_hs = 0, n_resp = 0;
   int exp_hs = 0, exp_resp = 0;
   int total = 0, bad = 0;
   logic [63:0] mem [logic [63:0]];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus_req_valid && bus_req_ready) n_hs <= n_hs + 1;
      if (resp_valid) n_resp <= n_resp + 1;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One client transaction; stall = bus_req_ready low cycles, delay = wait
   // cycles before the matching response, decoy = stray/misrouted responses.
   task automatic txn(input bit wr, input logic [63:0] a, input logic [63:0] d,
                      input int stall, input int delay, input bit decoy);
      logic [63:0] exp_data;
      int t0, exp_lat, hs0;
      bit seen;
      exp_data = (!wr && mem.exists(a)) ? mem[a] : 64'h0;
      exp_lat  = wr ? stall + 2 : stall + 3 + delay;
      chk("idle_req_ready", 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      tick();
      t0 = cyc; hs0 = n_hs;
      req_valid = 1'b0; req_write = 1'($urandom);
      req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
      chk("busy_req_ready", 64'(req_ready), 64'd0);
      bus_req_ready = 1'b0;
      for (int i = 0; i <= stall; i++) begin
         if (i > 0) tick();
         chk("pkt_valid", 64'(bus_req_valid), 64'd1);
         chk("pkt_type", 64'(bus_req_type), 64'(wr ? bus_write_data : bus_read_data));
         chk("pkt_addr", bus_req_address, a);
         chk("pkt_payload", bus_req_payload, wr ? d : 64'h0);
         chk("pkt_source", 64'(bus_req_source), 64'(SID));
         bus_resp_valid = decoy; bus_resp_dest = 4'(SID); bus_resp_payload = 64'hBAD;
      end
      bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
      chk("pkt_dropped", 64'(bus_req_valid), 64'd0);
      chk("one_handshake", 64'(n_hs - hs0), 64'd1);
      exp_hs++;
      if (!wr) begin
         for (int k = 0; k < delay; k++) begin
            bus_resp_valid = decoy && (k == 0);
            bus_resp_dest = 4'(SID + 1); bus_resp_payload = 64'hDEAD;
            tick();
            chk("early_resp", 64'(resp_valid), 64'd0);
         end
         bus_resp_valid = 1'b1; bus_resp_dest = 4'(SID); bus_resp_payload = exp_data;
         tick();
         bus_resp_valid = 1'b0; bus_resp_payload = {$urandom, $urandom};
      end
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (resp_valid) seen = 1'b1;
         else tick();
      end
      chk("resp_seen", 64'(seen), 64'd1);
      chk("resp_latency", 64'(cyc - t0 + 1), 64'(exp_lat));
      chk("resp_rdata", resp_rdata, exp_data);
      chk("resp_error", 64'(resp_error), 64'd0);
      exp_resp++;
      tick();
      chk("resp_pulse", 64'(resp_valid), 64'd0);
      chk("ready_again", 64'(req_ready), 64'd1);
      if (wr) mem[a] = d;
   endtask

   initial begin
      logic [63:0] addrs [4];
      int t0;
      bit seen;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_payload = '0; bus_resp_dest = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bus_valid", 64'(bus_req_valid), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_rdata", resp_rdata, 64'h0);
      chk("rst_addr", bus_req_address, 64'h0);
      reset = 1'b0;
      tick();
      chk("rst_req_ready", 64'(req_ready), 64'd1);

      txn(1'b1, 64'h100, 64'h1122334455667788, 0, 0, 1'b0);
      txn(1'b0, 64'h100, 64'h0, 0, 5, 1'b0);
      mem[64'h180] = {$urandom, $urandom};
      txn(1'b0, 64'h180, 64'h0, 4, 1, 1'b0);
      mem[64'h300] = 64'hBEEF;
      txn(1'b0, 64'h300, 64'h0, 0, 2, 1'b1);
      txn(1'b1, 64'h7, 64'hFFFF_0000_FFFF_0000, 2, 0, 1'b1);

      // Reset while waiting for a read; the late response must be dropped.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h700;
      tick();
      req_valid = 1'b0; bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0; exp_hs++;
      tick();
      reset = 1'b1; #1;
      chk("mid_rst_bus_valid", 64'(bus_req_valid), 64'd0);
      chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("mid_rst_rdata", resp_rdata, 64'h0);
      tick();
      reset = 1'b0;
      bus_resp_valid = 1'b1; bus_resp_dest = 4'(SID); bus_resp_payload = 64'hCAFE;
      tick();
      bus_resp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_no_resp", 64'(resp_valid), 64'd0);
         chk("post_rst_ready", 64'(req_ready), 64'd1);
         tick();
      end

`ifdef MEMORY_BUS_INITIATOR_TIMEOUT_EN
      req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h500;
      tick();
      t0 = cyc;
      req_valid = 1'b0; bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0; exp_hs++;
      seen = 1'b0;
      for (int i = 0; i < TO + 6 && !seen; i++) begin
         if (resp_valid) seen = 1'b1;
         else tick();
      end
      chk("to_seen", 64'(seen), 64'd1);
      chk("to_latency", 64'(cyc - t0 + 1), 64'(2 + TO));
      chk("to_error", 64'(resp_error), 64'd1);
      chk("to_rdata", resp_rdata, 64'h0);
      exp_resp++;
      tick();
      bus_resp_valid = 1'b1; bus_resp_dest = 4'(SID); bus_resp_payload = 64'h5A5A;
      tick();
      bus_resp_valid = 1'b0;
      chk("to_stale_ignored", 64'(resp_valid), 64'd0);
      chk("to_ready", 64'(req_ready), 64'd1);
`else
      mem[64'h500] = 64'h0123_4567_89AB_CDEF;
      txn(1'b0, 64'h500, 64'h0, 1, TO + 4, 1'b1);
`endif

      addrs[0] = 64'h100; addrs[1] = 64'h108; addrs[2] = 64'h2000; addrs[3] = 64'hFFFF_FFFF_FFFF_FFF8;
      for (int n = 0; n < 24; n++) begin
         txn(1'($urandom), addrs[$urandom_range(3, 0)], {$urandom, $urandom},
             int'($urandom_range(3, 0)), int'($urandom_range(5, 0)), 1'($urandom));
      end

      tick();
      chk("total_handshakes", 64'(n_hs), 64'(exp_hs));
      chk("total_responses", 64'(n_resp), 64'(exp_resp));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
